control_unit: RTL and testbench

Finite-state sequencer for the K&S 16-bit processor. It consumes the data path's decoded instruction and registered flags, and produces every data path control strobe plus the RAM write enable. It sits beside the data path in the top-level processor, which wires the two together.

---
 rtl/k_and_s_pkg.sv | 41 ++++
 rtl/control_unit_if.sv | 33 +++
 rtl/control_unit.sv | 142 ++++++++++++++
 tb/tb_control_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared types and ALU op encodings for the K&S 16-bit processor
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_LOAD_ADDR,
    S_LOAD_WB,
    S_STORE,
    S_MOVE,
    S_ALU_ADD,
    S_ALU_SUB,
    S_ALU_AND,
    S_ALU_OR,
    S_BRANCH,
    S_HALT
  } ctrl_state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - decode/flags in, control strobes out, between control unit and data path
interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic       zero_op;
  logic       neg_op;
  logic       unsigned_overflow;
  logic       signed_overflow;
  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       write_reg_enable;
  logic       flags_reg_enable;
  logic       ram_write_enable;
  logic       halt;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
  );

endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore sequencer driving the K&S data path strobes and RAM write enable
module control_unit
  import k_and_s_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master bus
);

  ctrl_state_t state_q, state_d;

  logic       branch_d;
  logic       pc_enable_d;
  logic       ir_enable_d;
  logic       addr_sel_d;
  logic       c_sel_d;
  logic [1:0] operation_d;
  logic       write_reg_enable_d;
  logic       flags_reg_enable_d;
  logic       ram_write_enable_d;
  logic       halt_d;

  // Carry/overflow flags are reserved for future branch types.
  logic unused_flags;
  assign unused_flags = bus.unsigned_overflow ^ bus.signed_overflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    branch_d           = 1'b0;
    pc_enable_d        = 1'b0;
    ir_enable_d        = 1'b0;
    addr_sel_d         = 1'b1;
    c_sel_d            = 1'b0;
    operation_d        = OP_ADD;
    write_reg_enable_d = 1'b0;
    flags_reg_enable_d = 1'b0;
    ram_write_enable_d = 1'b0;
    halt_d             = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_enable_d = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        pc_enable_d = 1'b1;
        case (bus.decoded_instruction)
          I_LOAD:   state_d = S_LOAD_ADDR;
          I_STORE:  state_d = S_STORE;
          I_MOVE:   state_d = S_MOVE;
          I_ADD:    state_d = S_ALU_ADD;
          I_SUB:    state_d = S_ALU_SUB;
          I_AND:    state_d = S_ALU_AND;
          I_OR:     state_d = S_ALU_OR;
          I_BRANCH: state_d = S_BRANCH;
          I_BZERO:  state_d = bus.zero_op  ? S_BRANCH : S_FETCH;
          I_BNZERO: state_d = !bus.zero_op ? S_BRANCH : S_FETCH;
          I_BNEG:   state_d = bus.neg_op   ? S_BRANCH : S_FETCH;
          I_BNNEG:  state_d = !bus.neg_op  ? S_BRANCH : S_FETCH;
          I_HALT:   state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      // Address phase covers the RAM's synchronous read latency.
      S_LOAD_ADDR: begin
        addr_sel_d = 1'b0;
        state_d    = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        addr_sel_d         = 1'b0;
        c_sel_d            = 1'b1;
        write_reg_enable_d = 1'b1;
        state_d            = S_FETCH;
      end
      S_STORE: begin
        addr_sel_d         = 1'b0;
        ram_write_enable_d = 1'b1;
        state_d            = S_FETCH;
      end
      S_MOVE: begin
        operation_d        = OP_OR;
        write_reg_enable_d = 1'b1;
        state_d            = S_FETCH;
      end
      S_ALU_ADD, S_ALU_SUB, S_ALU_AND, S_ALU_OR: begin
        case (state_q)
          S_ALU_SUB: operation_d = OP_SUB;
          S_ALU_AND: operation_d = OP_AND;
          S_ALU_OR:  operation_d = OP_OR;
          default:   operation_d = OP_ADD;
        endcase
        write_reg_enable_d = 1'b1;
        flags_reg_enable_d = 1'b1;
        state_d            = S_FETCH;
      end
      S_BRANCH: begin
        branch_d    = 1'b1;
        pc_enable_d = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        halt_d  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every strobe, even in the cycle the state is being forced.
    if (!rst_n) begin
      branch_d           = 1'b0;
      pc_enable_d        = 1'b0;
      ir_enable_d        = 1'b0;
      addr_sel_d         = 1'b1;
      c_sel_d            = 1'b0;
      operation_d        = OP_ADD;
      write_reg_enable_d = 1'b0;
      flags_reg_enable_d = 1'b0;
      ram_write_enable_d = 1'b0;
      halt_d             = 1'b0;
    end
  end

  assign bus.branch           = branch_d;
  assign bus.pc_enable        = pc_enable_d;
  assign bus.ir_enable        = ir_enable_d;
  assign bus.addr_sel         = addr_sel_d;
  assign bus.c_sel            = c_sel_d;
  assign bus.operation        = operation_d;
  assign bus.write_reg_enable = write_reg_enable_d;
  assign bus.flags_reg_enable = flags_reg_enable_d;
  assign bus.ram_write_enable = ram_write_enable_d;
  assign bus.halt             = halt_d;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench for control_unit: output word checked every cycle
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // {branch, pc_enable, ir_enable, addr_sel, c_sel, operation[1:0], wr_reg, flags, ram_we, halt}
  logic [10:0] obs;
  assign obs = {bus.branch, bus.pc_enable, bus.ir_enable, bus.addr_sel, bus.c_sel,
                bus.operation, bus.write_reg_enable, bus.flags_reg_enable,
                bus.ram_write_enable, bus.halt};

  localparam logic [10:0] E_RST    = 11'b0_0_0_1_0_00_0_0_0_0;
  localparam logic [10:0] E_FETCH  = 11'b0_0_1_1_0_00_0_0_0_0;
  localparam logic [10:0] E_DECODE = 11'b0_1_0_1_0_00_0_0_0_0;
  localparam logic [10:0] E_LDADDR = 11'b0_0_0_0_0_00_0_0_0_0;
  localparam logic [10:0] E_LDWB   = 11'b0_0_0_0_1_00_1_0_0_0;
  localparam logic [10:0] E_STORE  = 11'b0_0_0_0_0_00_0_0_1_0;
  localparam logic [10:0] E_MOVE   = 11'b0_0_0_1_0_11_1_0_0_0;
  localparam logic [10:0] E_ADD    = 11'b0_0_0_1_0_00_1_1_0_0;
  localparam logic [10:0] E_SUB    = 11'b0_0_0_1_0_01_1_1_0_0;
  localparam logic [10:0] E_AND    = 11'b0_0_0_1_0_10_1_1_0_0;
  localparam logic [10:0] E_OR     = 11'b0_0_0_1_0_11_1_1_0_0;
  localparam logic [10:0] E_BRANCH = 11'b1_1_0_1_0_00_0_0_0_0;
  localparam logic [10:0] E_HALT   = 11'b0_0_0_1_0_00_0_0_0_1;

  task automatic chk(input string tag, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [10:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    rst_n                   = 1'b0;
    bus.decoded_instruction = I_NOP;
    bus.zero_op             = 1'b0;
    bus.neg_op              = 1'b0;
    bus.unsigned_overflow   = 1'b0;
    bus.signed_overflow     = 1'b0;

    step("reset_hold", E_RST);
    step("reset_hold2", E_RST);
    rst_n = 1'b1;
    #1 chk("first_fetch", E_FETCH);

    step("nop_decode", E_DECODE);
    step("nop_fetch", E_FETCH);
    step("nop_decode2", E_DECODE);
    step("nop_fetch2", E_FETCH);

    bus.decoded_instruction = I_ADD;
    step("add_decode", E_DECODE); step("add_exec", E_ADD); step("add_fetch", E_FETCH);
    bus.decoded_instruction = I_SUB;
    step("sub_decode", E_DECODE); step("sub_exec", E_SUB); step("sub_fetch", E_FETCH);
    bus.decoded_instruction = I_AND;
    step("and_decode", E_DECODE); step("and_exec", E_AND); step("and_fetch", E_FETCH);
    bus.decoded_instruction = I_OR;
    step("or_decode", E_DECODE); step("or_exec", E_OR); step("or_fetch", E_FETCH);
    bus.decoded_instruction = I_MOVE;
    step("move_decode", E_DECODE); step("move_exec", E_MOVE); step("move_fetch", E_FETCH);

    bus.decoded_instruction = I_LOAD;
    step("load_decode", E_DECODE); step("load_addr", E_LDADDR);
    step("load_wb", E_LDWB); step("load_fetch", E_FETCH);
    bus.decoded_instruction = I_STORE;
    step("store_decode", E_DECODE); step("store_exec", E_STORE); step("store_fetch", E_FETCH);

    bus.decoded_instruction = I_BRANCH;
    step("br_decode", E_DECODE); step("br_taken", E_BRANCH); step("br_fetch", E_FETCH);

    bus.decoded_instruction = I_BZERO; bus.zero_op = 1'b1; bus.neg_op = 1'b0;
    step("bz_t_decode", E_DECODE); step("bz_t_branch", E_BRANCH); step("bz_t_fetch", E_FETCH);
    bus.zero_op = 1'b0; bus.neg_op = 1'b1;
    step("bz_n_decode", E_DECODE); step("bz_n_fetch", E_FETCH);

    bus.decoded_instruction = I_BNZERO; bus.zero_op = 1'b0; bus.neg_op = 1'b1;
    step("bnz_t_decode", E_DECODE); step("bnz_t_branch", E_BRANCH); step("bnz_t_fetch", E_FETCH);
    bus.zero_op = 1'b1; bus.neg_op = 1'b0;
    step("bnz_n_decode", E_DECODE); step("bnz_n_fetch", E_FETCH);

    bus.decoded_instruction = I_BNEG; bus.neg_op = 1'b1; bus.zero_op = 1'b0;
    step("bn_t_decode", E_DECODE); step("bn_t_branch", E_BRANCH); step("bn_t_fetch", E_FETCH);
    bus.neg_op = 1'b0; bus.zero_op = 1'b1;
    step("bn_n_decode", E_DECODE); step("bn_n_fetch", E_FETCH);

    bus.decoded_instruction = I_BNNEG; bus.neg_op = 1'b0; bus.zero_op = 1'b1;
    step("bnn_t_decode", E_DECODE); step("bnn_t_branch", E_BRANCH); step("bnn_t_fetch", E_FETCH);
    bus.neg_op = 1'b1; bus.zero_op = 1'b0;
    step("bnn_n_decode", E_DECODE); step("bnn_n_fetch", E_FETCH);

    bus.decoded_instruction = decoded_instruction_type'(4'hF);
    step("undef_decode", E_DECODE); step("undef_fetch", E_FETCH);

    // Reset while the load is in its address phase: write-back must never appear.
    bus.decoded_instruction = I_LOAD;
    step("abort_decode", E_DECODE); step("abort_addr", E_LDADDR);
    rst_n = 1'b0;
    #1 chk("abort_rst_comb", E_RST);
    step("abort_rst_edge", E_RST);
    rst_n = 1'b1;
    bus.decoded_instruction = I_NOP;
    #1 chk("abort_resume_fetch", E_FETCH);
    step("abort_resume_decode", E_DECODE);
    step("abort_resume_fetch2", E_FETCH);

    bus.decoded_instruction = I_HALT;
    step("halt_decode", E_DECODE);
    step("halt_enter", E_HALT);
    bus.decoded_instruction = I_ADD;
    for (int i = 0; i < 22; i++) step("halt_hold", E_HALT);
    rst_n = 1'b0;
    #1 chk("halt_rst_comb", E_RST);
    step("halt_rst_edge", E_RST);
    rst_n = 1'b1;
    bus.decoded_instruction = I_NOP;
    #1 chk("halt_exit_fetch", E_FETCH);
    step("halt_exit_decode", E_DECODE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
